// File: rtl/pwm_pkg.sv
// Shared PWM definitions: duty width, free-running period and ramp FSM states.
package pwm_pkg;
    localparam int DUTY_W     = 8;
    localparam int PWM_PERIOD = 256;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_t;
endpackage

// File: rtl/pwm_frame_timer.sv
// Free-running frame counter, phase-locked to the downstream PWM counter.
// frame_evt_o marks the last count before the PWM latch cycle.
module pwm_frame_timer #(
    parameter int PERIOD = 256
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_evt_o
);
    localparam int CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(PERIOD - 1)) count_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign frame_evt_o = (count_q == CNT_W'(PERIOD - 2));
endmodule

// File: rtl/pwm_duty_ramp.sv
// Frame-aligned duty ramp feeding the PWM DutyCycle input.
// Define DUTY_RAMP_RETARGET_EN to allow a new target to be accepted mid-ramp.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int WIDTH         = DUTY_W,
    parameter int PERIOD        = PWM_PERIOD,
    parameter int STEP_PERIOD_W = 16
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic [WIDTH-1:0]         Target,
    input  logic                     TargetValid,
    output logic                     TargetReady,
    input  logic [WIDTH-1:0]         StepSize,
    input  logic [STEP_PERIOD_W-1:0] StepPeriod,
    output logic [WIDTH-1:0]         DutyCycle,
    output logic                     Busy,
    output logic                     Done
);
    ramp_state_t              state_q, state_d;
    logic [WIDTH-1:0]         duty_q, duty_d;
    logic [WIDTH-1:0]         tgt_q, tgt_d;
    logic [WIDTH-1:0]         step_q, step_d;
    logic [STEP_PERIOD_W-1:0] sper_q, sper_d;
    logic [STEP_PERIOD_W-1:0] scnt_q, scnt_d;
    logic                     done_q, done_d;
    logic                     frame_evt;
    logic                     accept;
    logic [WIDTH-1:0]         duty_next;

    pwm_frame_timer #(.PERIOD(PERIOD)) u_frame_timer (
        .clk         (Clk),
        .rst_n       (nReset),
        .frame_evt_o (frame_evt)
    );

    // Extra bit catches overflow/borrow so the result clamps at the target.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] d,
                                                     input logic [WIDTH-1:0] s,
                                                     input logic [WIDTH-1:0] t);
        logic [WIDTH:0] up;
        logic [WIDTH:0] dn;
        up = {1'b0, d} + {1'b0, s};
        dn = {1'b0, d} - {1'b0, s};
        if (t > d) step_toward = (up > {1'b0, t}) ? t : up[WIDTH-1:0];
        else       step_toward = (dn[WIDTH] || (dn[WIDTH-1:0] < t)) ? t : dn[WIDTH-1:0];
    endfunction

`ifdef DUTY_RAMP_RETARGET_EN
    assign TargetReady = 1'b1;
`else
    assign TargetReady = (state_q == IDLE);
`endif

    assign accept    = TargetValid & TargetReady;
    assign duty_next = step_toward(duty_q, step_q, tgt_q);

    // An accept wins over a coincident frame event, so that event is not counted.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        sper_d  = sper_q;
        scnt_d  = scnt_q;
        done_d  = 1'b0;
        if (accept) begin
            tgt_d  = Target;
            step_d = (StepSize == '0) ? WIDTH'(1) : StepSize;
            sper_d = (StepPeriod == '0) ? STEP_PERIOD_W'(1) : StepPeriod;
            scnt_d = '0;
            if (Target == duty_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (state_q == RAMP && frame_evt) begin
            if (scnt_q == sper_q - STEP_PERIOD_W'(1)) begin
                scnt_d = '0;
                duty_d = duty_next;
                if (duty_next == tgt_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end else begin
                scnt_d = scnt_q + STEP_PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= WIDTH'(1);
            sper_q  <= STEP_PERIOD_W'(1);
            scnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            sper_q  <= sper_d;
            scnt_q  <= scnt_d;
            done_q  <= done_d;
        end
    end

    assign DutyCycle = duty_q;
    assign Busy      = (state_q == RAMP);
    assign Done      = done_q;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Self-checking bench for pwm_duty_ramp: directed and random ramps against a frame-level model.
module tb_pwm_duty_ramp;
    localparam int PERIOD = 256;
    localparam int LIMIT  = 300 * PERIOD;

    logic        Clk = 1'b0;
    logic        nReset = 1'b0;
    logic [7:0]  Target = '0;
    logic        TargetValid = 1'b0;
    logic        TargetReady;
    logic [7:0]  StepSize = '0;
    logic [15:0] StepPeriod = '0;
    logic [7:0]  DutyCycle;
    logic        Busy;
    logic        Done;

    int ncmp = 0;
    int nfail = 0;
    int md = 0;      // model duty
    int tb_fc = 0;   // model of the PWM counter
    int pwm_lat = 0; // value a downstream PWM would latch

`ifdef DUTY_RAMP_RETARGET_EN
    localparam int RDY_RAMP = 1;
`else
    localparam int RDY_RAMP = 0;
`endif

    pwm_duty_ramp dut (
        .Clk         (Clk),
        .nReset      (nReset),
        .Target      (Target),
        .TargetValid (TargetValid),
        .TargetReady (TargetReady),
        .StepSize    (StepSize),
        .StepPeriod  (StepPeriod),
        .DutyCycle   (DutyCycle),
        .Busy        (Busy),
        .Done        (Done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge nReset) begin
        if (!nReset) tb_fc <= 0;
        else         tb_fc <= (tb_fc + 1) % PERIOD;
    end

    always @(posedge Clk) begin
        if (nReset && tb_fc == PERIOD - 1) pwm_lat <= int'(DutyCycle);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int d, input int s, input int t);
        if (t > d) return (d + s > t) ? t : d + s;
        return (d - s < t) ? t : d - s;
    endfunction

    // Accept a target, then follow the ramp cycle by cycle until Done.
    task automatic ramp(input int tgt, input int s, input int p, input bit hold,
                        input int rt_at, input int rt_tgt);
        int se, pe, fr, cyc;
        bit evt, fin, rt_pend;
        se = (s == 0) ? 1 : s;
        pe = (p == 0) ? 1 : p;
        @(negedge Clk);
        Target = 8'(tgt); StepSize = 8'(s); StepPeriod = 16'(p); TargetValid = 1'b1;
        @(posedge Clk); #1;
        TargetValid = hold;
        Target = hold ? 8'((tgt + 77) % 256) : 8'(tgt);
        if (tgt == md) begin
            TargetValid = 1'b0;
            chk("eq_done", int'(Done), 1);
            chk("eq_busy", int'(Busy), 0);
            chk("eq_duty", int'(DutyCycle), md);
            chk("eq_rdy", int'(TargetReady), 1);
            @(posedge Clk); #1;
            chk("eq_done_clr", int'(Done), 0);
            return;
        end
        fr = 0; fin = 1'b0; cyc = 0; rt_pend = (rt_at >= 0);
        while (!fin && cyc < LIMIT) begin
            @(negedge Clk);
            cyc++;
            chk("duty", int'(DutyCycle), md);
            chk("busy", int'(Busy), 1);
            chk("done_low", int'(Done), 0);
            chk("rdy_ramp", int'(TargetReady), RDY_RAMP);
            evt = (tb_fc == PERIOD - 2);
            if (rt_pend && md == rt_at && !evt) begin
                Target = 8'(rt_tgt); TargetValid = 1'b1;
                @(posedge Clk); #1;
                TargetValid = 1'b0;
                tgt = rt_tgt; fr = 0; rt_pend = 1'b0;
                if (tgt == md) fin = 1'b1;
            end else begin
                @(posedge Clk); #1;
                if (evt) begin
                    fr++;
                    if (fr % pe == 0) begin
                        md = nxt(md, se, tgt);
                        if (md == tgt) fin = 1'b1;
                    end
                end
            end
            if (fin) begin
                TargetValid = 1'b0;
                chk("fin_duty", int'(DutyCycle), tgt);
                chk("fin_done", int'(Done), 1);
                chk("fin_busy", int'(Busy), 0);
                chk("fin_rdy", int'(TargetReady), 1);
                @(posedge Clk); #1;
                chk("fin_done_clr", int'(Done), 0);
                chk("pwm_latch", pwm_lat, tgt);
            end
        end
        if (!fin) chk("ramp_timeout", 0, 1);
    endtask

    initial begin
        // Reset asserted from time 0; outputs must already be at reset values.
        #12;
        chk("rst_duty", int'(DutyCycle), 0);
        chk("rst_rdy", int'(TargetReady), 1);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        @(negedge Clk); nReset = 1'b1;
        md = 0;

        ramp(10, 4, 1, 1'b0, -1, 0);      // 4, 8, 10
        ramp(10, 4, 1, 1'b0, -1, 0);      // equal target
        ramp(200, 255, 1, 1'b0, -1, 0);   // clamp up to 200
        ramp(3, 100, 2, 1'b0, -1, 0);     // 100 then 3
        ramp(0, 255, 1, 1'b0, -1, 0);
        ramp(2, 0, 0, 1'b0, -1, 0);       // treated as 1/1
        ramp(2, 0, 0, 1'b0, -1, 0);       // equal target
`ifdef DUTY_RAMP_RETARGET_EN
        ramp(0, 255, 1, 1'b0, -1, 0);
        ramp(100, 10, 1, 1'b0, 60, 50);   // reverses at 60, stops at 50
`else
        ramp(40, 20, 1, 1'b1, -1, 0);     // TargetValid held during ramp
`endif
        for (int i = 0; i < 8; i++) begin
            ramp(int'($urandom_range(0, 255)), int'($urandom_range(32, 255)),
                 int'($urandom_range(0, 2)), 1'b0, -1, 0);
        end

        // Reset in the middle of a ramp.
        if (md == 250) ramp(0, 255, 1, 1'b0, -1, 0);
        @(negedge Clk);
        Target = 8'd250; StepSize = 8'd10; StepPeriod = 16'd1; TargetValid = 1'b1;
        @(posedge Clk); #1 TargetValid = 1'b0;
        repeat (600) @(posedge Clk);
        #2 nReset = 1'b0;
        #1;
        chk("mid_rst_duty", int'(DutyCycle), 0);
        chk("mid_rst_busy", int'(Busy), 0);
        chk("mid_rst_rdy", int'(TargetReady), 1);
        chk("mid_rst_done", int'(Done), 0);
        md = 0;
        repeat (2) @(negedge Clk);
        nReset = 1'b1;
        ramp(5, 5, 1, 1'b0, -1, 0);       // first step timing relies on counter restart

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
